// File: rtl/mult16_seq.sv
// mult16_seq: 16x16 unsigned sequential multiplier built on one time-shared
// 8x8 multiplier. Four partial products (LL, LH, HL, HH) are accumulated over
// four cycles; P is loaded on the edge entering DONE.
// Optional feature: define MULT16_ACC_EN to add the acc_en port, which seeds
// the accumulator with the current P so that P_new = P_old + A*B (mod 2^32).

module mult8x8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  // Plain 8x8 unsigned product
  assign o_p = 16'(i_a) * 16'(i_b);
endmodule

module mult16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
`ifdef MULT16_ACC_EN
  input  logic        acc_en,
`endif
  output logic [31:0] P,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LL   = 3'd1,
    S_LH   = 3'd2,
    S_HL   = 3'd3,
    S_HH   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [31:0] r_acc;
  logic [31:0] r_p;
  logic        r_busy;
  logic        r_done;

  logic        w_accept;
  logic [7:0]  w_mul_a;
  logic [7:0]  w_mul_b;
  logic [15:0] w_pp;
  logic [31:0] w_pp_sh;
  logic [31:0] w_acc_sum;
  logic [31:0] w_acc_init;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  // A new operation is accepted only from IDLE or DONE
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef MULT16_ACC_EN
  assign w_acc_init = acc_en ? r_p : 32'd0;
`else
  assign w_acc_init = 32'd0;
`endif

  // Operand byte selection for the shared multiplier
  assign w_mul_a = ((r_state == S_HL) || (r_state == S_HH)) ? r_a[15:8] : r_a[7:0];
  assign w_mul_b = ((r_state == S_LH) || (r_state == S_HH)) ? r_b[15:8] : r_b[7:0];

  mult8x8 u_mult8x8 (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_pp)
  );

  // Align the partial product to its weight for the current state
  always_comb begin
    w_pp_sh = 32'd0;
    case (r_state)
      S_LL:       w_pp_sh = {16'd0, w_pp};
      S_LH, S_HL: w_pp_sh = {8'd0, w_pp, 8'd0};
      S_HH:       w_pp_sh = {w_pp, 16'd0};
      default:    w_pp_sh = 32'd0;
    endcase
  end

  assign w_acc_sum = r_acc + w_pp_sh;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? S_LL : S_IDLE;
      S_LL:    w_state_nxt = S_LH;
      S_LH:    w_state_nxt = S_HL;
      S_HL:    w_state_nxt = S_HH;
      S_HH:    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_LL : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_LL, S_LH, S_HL, S_HH: w_busy_nxt = 1'b1;
      S_DONE:                 w_done_nxt = 1'b1;
      default:                ;
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Operand capture, partial-product accumulation and result load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= 16'd0;
      r_b   <= 16'd0;
      r_acc <= 32'd0;
      r_p   <= 32'd0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_acc <= w_acc_init;
    end else if (r_busy) begin
      r_acc <= w_acc_sum;
      if (r_state == S_HH) r_p <= w_acc_sum;
    end
  end

  assign P    = r_p;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_mult16_seq.sv
// Scoreboard bench for mult16_seq: stimulus pushes hand-computed products,
// a monitor pops and compares P on every done pulse.
// Define MULT16_ACC_EN to also exercise the accumulate mode.

module tb_mult16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] P;
  logic        busy;
  logic        done;
`ifdef MULT16_ACC_EN
  logic        acc_en;
`endif

  int          total;
  int          bad;
  logic [31:0] exp_q[$];

  mult16_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
`ifdef MULT16_ACC_EN
    .acc_en (acc_en),
`endif
    .P      (P),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare P against the scoreboard on each done pulse
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: actual P=0x%08h required=no done", P);
      end else begin
        check("result_P", P, exp_q.pop_front());
      end
    end
  end

  // One start pulse, then check busy length, done count and latency
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string tag);
    int bc, dc, d1;
    bc = 0; dc = 0; d1 = -1;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    exp_q.push_back(exp);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        A = ~a;
        B = ~b;
      end
      if (busy) bc++;
      if (done) begin
        dc++;
        if (d1 < 0) d1 = i;
      end
    end
    check({tag, "_busy_cycles"}, 32'(bc), 32'd4);
    check({tag, "_done_pulses"}, 32'(dc), 32'd1);
    check({tag, "_done_latency"}, 32'(d1), 32'd5);
  endtask

  initial begin
    int bc, dc, d1, d2;
    clk = 1'b0; rst = 1'b1; start = 1'b0; A = 16'd0; B = 16'd0;
    total = 0; bad = 0;
`ifdef MULT16_ACC_EN
    acc_en = 1'b0;
`endif

    // Reset for two cycles
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_P", P, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // Single operation
    run_op(16'h1234, 16'h5678, 32'h06260060, "basic");

    // Back-to-back with start held high; A/B change while busy
    @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    exp_q.push_back(32'hFFFE0001);
    exp_q.push_back(32'h00000006);
    dc = 0; d1 = -1; d2 = -1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) begin A = 16'h0002; B = 16'h0003; end
      if (i == 6) start = 1'b0;
      if (done) begin
        dc++;
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
    end
    check("b2b_done_pulses", 32'(dc), 32'd2);
    check("b2b_first_latency", 32'(d1), 32'd5);
    check("b2b_spacing", 32'(d2 - d1), 32'd5);

    // start pulsed during LH is ignored
    @(negedge clk);
    A = 16'h0003; B = 16'h0005; start = 1'b1;
    exp_q.push_back(32'h0000000F);
    dc = 0; bc = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
      if (busy) bc++;
      if (done) dc++;
    end
    check("ignore_done_pulses", 32'(dc), 32'd1);
    check("ignore_busy_cycles", 32'(bc), 32'd4);

    // Reset during HL aborts the operation
    @(negedge clk);
    A = 16'h00FF; B = 16'h00FF; start = 1'b1;
    exp_q.push_back(32'h0000FE01);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_P", P, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("abort_no_done", 32'(dc), 32'd0);
    run_op(16'h00FF, 16'h00FF, 32'h0000FE01, "after_reset");

`ifdef MULT16_ACC_EN
    // Accumulate mode, including wrap modulo 2^32
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "acc_plain");
    acc_en = 1'b1;
    run_op(16'h0001, 16'hFFFF, 32'hFFFF0000, "acc_add");
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFD0001, "acc_wrap");
    acc_en = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the run
  initial begin
    #200000;
    $display("FAIL timeout: actual=no finish required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult16_seq.md
MULT16_SEQ -- requirements
Module: mult16_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 The port clk SHALL be an input, 1 bit wide, carrying the single clock; all state updates occur on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide: an asynchronous, active-high reset.
REQ-004 The port start SHALL be an input, 1 bit wide, requesting a multiply; it is sampled on the rising edge of clk.
REQ-005 The port A SHALL be an input, 16 bits wide, carrying the unsigned multiplicand.
REQ-006 The port B SHALL be an input, 16 bits wide, carrying the unsigned multiplier.
REQ-007 The port P SHALL be an output, 32 bits wide, carrying the registered result.
REQ-008 The port busy SHALL be an output, 1 bit wide, high while an operation is in progress.
REQ-009 The port done SHALL be an output, 1 bit wide, a one-cycle pulse indicating that P has just been updated.
REQ-010 The port acc_en SHALL be an input, 1 bit wide, present only when MULT16_ACC_EN is defined (see Configuration).

Function
REQ-011 The block SHALL compute the 16x16 unsigned product using exactly one instance of the existing 8x8 unsigned multiplier (mult8x8), time-shared over four cycles.
REQ-012 The FSM states SHALL be IDLE, LL, LH, HL, HH and DONE, each lasting one cycle except IDLE.
- LL computes A[7:0]*B[7:0].
- LH computes A[7:0]*B[15:8].
- HL computes A[15:8]*B[7:0].
- HH computes A[15:8]*B[15:8].
REQ-013 When start is high in IDLE or DONE, the block SHALL latch A and B into internal operand registers, clear the internal 32-bit accumulator, and transition to LL.
REQ-014 Transitions LL->LH->HL->HH->DONE SHALL occur unconditionally on successive edges, and DONE SHALL go to IDLE when start is low.
REQ-015 Each partial product SHALL be zero-extended and added into the accumulator at its shift:
- LL at shift 0.
- LH and HL at shift 8.
- HH at shift 16.
REQ-016 The 32-bit accumulation SHALL be modulo 2^32, with no overflow flag.
REQ-017 P SHALL be loaded from the final accumulator value on the edge entering DONE, and SHALL otherwise hold its value (P is unchanged during busy).
REQ-018 Latency: counting the edge that accepts start as edge 1, done SHALL be high during the cycle after edge 5, with P valid in that same cycle.
REQ-019 busy SHALL be high in LL, LH, HL and HH, and low in IDLE and DONE.
REQ-020 done SHALL be high only in DONE.
REQ-021 start asserted while busy is high SHALL be ignored, with no queuing.
REQ-022 Changes on A and B while busy SHALL NOT affect the result in progress.
REQ-023 start held high continuously SHALL issue back-to-back operations with a throughput of one result per 5 cycles (DONE->LL directly).

Reset
REQ-024 While rst is high, the block SHALL asynchronously force:
- state = IDLE.
- P = 0.
- busy = 0.
- done = 0.
- accumulator = 0.
- operand registers = 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse, and the first start after rst is released SHALL execute normally.

Configuration
REQ-026 The macro MULT16_ACC_EN SHALL control the accumulate mode.
REQ-027 When MULT16_ACC_EN is defined:
- The acc_en port SHALL exist.
- If acc_en is high on the start-accepting edge, the accumulator SHALL be initialised to the current P instead of 0, giving P_new = (P_old + A*B) mod 2^32.
- acc_en SHALL be ignored on all other edges.
REQ-028 When MULT16_ACC_EN is undefined, the acc_en port SHALL be absent and the accumulator SHALL always initialise to 0.

Verification
REQ-029 The bench SHALL apply rst for 2 cycles and then release it -> P=0x00000000, busy=0, done=0.
REQ-030 The bench SHALL run A=0x1234, B=0x5678 with a one-cycle start:
- busy is high for exactly 4 cycles.
- done pulses once, 5 edges after start.
- P=0x06260060.
REQ-031 The bench SHALL hold start high with A=0xFFFF, B=0xFFFF for the first operation, then switch A/B to 0x0002/0x0003 during its busy period:
- First result P=0xFFFE0001.
- Next result P=0x00000006.
- The two done pulses are 5 cycles apart.
REQ-032 The bench SHALL pulse start during LH -> it is ignored, with exactly one done pulse and no second operation.
REQ-033 The bench SHALL assert rst during HL of A=0x00FF, B=0x00FF -> busy and done drop immediately and P=0, then a new start with 0x00FF*0x00FF yields P=0x0000FE01.
REQ-034 With MULT16_ACC_EN defined, the bench SHALL run:
- 0xFFFF*0xFFFF -> P=0xFFFE0001.
- Then acc_en=1 with 0x0001*0xFFFF -> P=0xFFFF0000.
- Then acc_en=1 with 0xFFFF*0xFFFF -> P=0xFFFD0001 (wrap).
